// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if
// CPU-side register bus for the UART transmitter. The hub drives the
// master side; the peripheral is the slave side.
//   addr    : register offset from the hub (only [3:2] are decoded)
//   datain  : CPU store data
//   we      : hub-qualified write strobe, one cycle per store
//   dataout : combinational read data for the current addr
interface io_uart_tx_if;
    logic [7:0]  addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;

    modport master (
        output addr,
        output datain,
        output we,
        input  dataout
    );

    modport slave (
        input  addr,
        input  datain,
        input  we,
        output dataout
    );
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx
// Memory-mapped 8N1 UART transmitter. CPU stores to TXDATA are queued in a
// small FIFO and shifted out LSB first at a programmable bit period.
//
// Ports
//   clk    : system clock, all state on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : register bus (slave side), see io_uart_tx_if
//   tx     : serial output, idle high
//
// Register map (addr[3:2])
//   0 TXDATA : write pushes datain[7:0]; reads 0
//   1 STATUS : {count[15:8], overflow[3], busy[2], empty[1], full[0]};
//              write with datain[3]=1 clears overflow
//   2 DIV    : bit period in clk cycles, [15:0]; a written 0 is stored as 1
//   3        : reads 0, writes ignored
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | tx high, waiting for a byte in the FIFO
// START | tx low for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | tx high for one bit period, then chain straight into the next byte
module io_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 434
) (
    input  logic         clk,
    input  logic         reset,
    io_uart_tx_if.slave  bus,
    output logic         tx
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [15:0]     RESET_DIV = 16'(DEFAULT_DIV);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_div;

    assign reg_sel   = bus.addr[3:2];
    assign wr_txdata = bus.we && (reg_sel == 2'd0);
    assign wr_status = bus.we && (reg_sel == 2'd1);
    assign wr_div    = bus.we && (reg_sel == 2'd2);

    // Bus bits that carry no meaning for this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[7:4], bus.addr[1:0], bus.datain[31:16]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // Full is judged on the pre-edge count, so a push that meets a full
    // FIFO is dropped even if the FSM pops on the same edge.
    assign push  = wr_txdata && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.datain[7:0];
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [15:0] div_reg;
    logic        overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg  <= RESET_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_div) begin
                div_reg <= (bus.datain[15:0] == 16'd0) ? 16'd1 : bus.datain[15:0];
            end
            if (wr_txdata && full) begin
                overflow <= 1'b1;
            end else if (wr_status && bus.datain[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic [15:0] frame_div;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        timer_done;
    logic        busy;

    assign timer_done = (timer == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (timer_done) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (timer_done && (bit_cnt == 3'd7)) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (timer_done) begin
                    state_nxt = empty ? S_IDLE : S_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        pop  = 1'b0;
        busy = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                pop  = !empty;
            end
            S_START: tx = 1'b0;
            S_DATA:  tx = shift[0];
            S_STOP:  pop = timer_done && !empty;
            default: busy = 1'b0;
        endcase
    end

    // The divisor is latched per frame so DIV writes never disturb a frame
    // already on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= 16'd0;
            frame_div <= RESET_DIV;
            shift     <= 8'd0;
            bit_cnt   <= 3'd0;
        end else if (pop) begin
            shift     <= fifo_mem[rd_ptr];
            frame_div <= div_reg;
            timer     <= div_reg - 16'd1;
            bit_cnt   <= 3'd0;
        end else if (state != S_IDLE) begin
            if (timer_done) begin
                timer <= frame_div - 16'd1;
                if (state == S_DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                timer <= timer - 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.dataout = 32'd0;
        case (reg_sel)
            2'd1: begin
                bus.dataout[0]    = full;
                bus.dataout[1]    = empty;
                bus.dataout[2]    = busy;
                bus.dataout[3]    = overflow;
                bus.dataout[15:8] = {{(8 - CW){1'b0}}, count};
            end
            2'd2:    bus.dataout[15:0] = div_reg;
            default: bus.dataout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;

    localparam int DEPTH   = 8;
    localparam int DEF_DIV = 434;

    localparam logic [7:0] A_TXDATA = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_DIV    = 8'h08;
    localparam logic [7:0] A_RSVD   = 8'h0C;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;

    io_uart_tx_if bus();

    io_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (frame-level view of the peripheral)
    logic [7:0] m_fifo[$];
    frame_t     sb_q[$];
    int         m_div = DEF_DIV;
    bit         m_ovf = 1'b0;
    bit         m_idle = 1'b1;
    int         m_end = 0;
    int         m_last_start = 0;
    int         rst_gen = 0;

    // Monitor observations
    int last_fall = 0;
    bit mon_busy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (m_fifo.size() == DEPTH);
        s[1]     = (m_fifo.size() == 0);
        s[2]     = !m_idle;
        s[3]     = m_ovf;
        s[15:8]  = 8'(m_fifo.size());
        return s;
    endfunction

    // Model: per edge, a frame starts whenever the FIFO holds a byte and the
    // line is idle or the previous frame's 10 bit periods have just elapsed.
    initial begin : model
        int e;
        int pre;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            e = cyc + 1;
            if (reset) begin
                m_fifo.delete();
                sb_q.delete();
                m_idle = 1'b1;
                m_ovf  = 1'b0;
                m_div  = DEF_DIV;
                rst_gen++;
            end else begin
                pre = m_fifo.size();
                if (pre > 0 && (m_idle || e == m_end)) begin
                    b = m_fifo.pop_front();
                    sb_q.push_back('{data: b, div: m_div, start: e});
                    m_end        = e + 10 * m_div;
                    m_idle       = 1'b0;
                    m_last_start = e;
                end else if (!m_idle && e == m_end) begin
                    m_idle = 1'b1;
                end
                if (bus.we) begin
                    case (bus.addr[3:2])
                        2'd0: begin
                            if (pre < DEPTH) m_fifo.push_back(bus.datain[7:0]);
                            else m_ovf = 1'b1;
                        end
                        2'd1: if (bus.datain[3]) m_ovf = 1'b0;
                        2'd2: m_div = (bus.datain[15:0] == 16'd0) ? 1 : int'(bus.datain[15:0]);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Monitor: whenever the line goes low outside a frame, pop the next
    // expected frame and check every cycle of its 10 bit periods.
    initial begin : monitor
        frame_t     f;
        int         gen;
        int         errs;
        int         lvl;
        bit         aborted;
        logic [7:0] dec;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: tx low at cycle %0d, no byte expected", cyc);
                end else begin
                    f        = sb_q.pop_front();
                    gen      = rst_gen;
                    errs     = 0;
                    dec      = 8'd0;
                    aborted  = 1'b0;
                    mon_busy = 1'b1;
                    last_fall = cyc;
                    check("frame_start", cyc, f.start);
                    for (int i = 0; i < 10 * f.div; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst_gen != gen) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (i < f.div) lvl = 0;
                        else if (i < 9 * f.div) lvl = int'(f.data[(i - f.div) / f.div]);
                        else lvl = 1;
                        if (tx !== lvl[0]) errs++;
                        if (i >= f.div && i < 9 * f.div && ((i - f.div) % f.div) == f.div / 2)
                            dec[(i - f.div) / f.div] = tx;
                    end
                    if (!aborted) begin
                        check("frame_data", dec, f.data);
                        check("frame_wave_errs", errs, 0);
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic drive_write(input logic [7:0] a, input logic [31:0] d);
        bus.addr   = a;
        bus.datain = d;
        bus.we     = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_write(a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        d = bus.dataout;
    endtask

    task automatic wait_drain(input int max);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (n < max && !done) begin
            @(negedge clk);
            #2;
            done = (sb_q.size() == 0) && (m_fifo.size() == 0) && m_idle && !mon_busy;
            n++;
        end
        check("drain_done", done, 1);
    endtask

    // Cycles from the latest tx fall until STATUS.busy reads low.
    task automatic busy_span(output int span, input int max);
        logic [31:0] rd;
        bit low;
        low = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < max && !low; n++) begin
            bus_read(A_STATUS, rd);
            low = !rd[2];
        end
        check("busy_low_seen", low, 1);
        span = cyc - last_fall;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] rd;
        int span;
        int wr_edge;
        int first_start;
        int a_start;
        int target;
        int tcount;
        logic prev_tx;
        int op;

        bus.addr   = 8'd0;
        bus.datain = 32'd0;
        bus.we     = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state and register map
        bus_read(A_STATUS, rd);  check("reset_status", rd, 32'h0000_0002);
        bus_read(A_DIV, rd);     check("reset_div", rd, 434);
        check("reset_tx", tx, 1);
        bus_read(A_TXDATA, rd);  check("txdata_reads_zero", rd, 0);
        bus_read(A_RSVD, rd);    check("rsvd_reads_zero", rd, 0);
        bus_write(A_RSVD | 8'h03, 32'hFFFF_FFFF);
        bus_read(8'hF9, rd);     check("div_alias_addr", rd, 434);

        // Single frame at DIV=4
        bus_write(A_DIV, 4);
        bus_write(A_TXDATA, 32'h0000_0055);
        wr_edge = cyc;
        busy_span(span, 200);
        check("fall_after_write", last_fall - wr_edge, 1);
        check("busy_span_div4", span, 40);
        wait_drain(500);

        // Burst of 10 writes at DIV=2: 9 accepted, 10th dropped
        bus_write(A_DIV, 2);
        for (int i = 1; i <= 10; i++) bus_write(A_TXDATA, 32'(i));
        first_start = m_last_start;
        bus_read(A_STATUS, rd);
        check("burst_status", rd, 32'h0000_080D);
        check("burst_status_model", rd, model_status());
        wait_drain(1000);
        check("burst_back_to_back", last_fall - first_start, 160);
        bus_read(A_STATUS, rd);  check("ovf_sticky", rd[3], 1);
        bus_write(A_STATUS, 32'd8);
        bus_read(A_STATUS, rd);  check("ovf_cleared", rd, 32'h0000_0002);

        // DIV change mid-frame applies to the next frame only
        bus_write(A_DIV, 4);
        bus_write(A_TXDATA, 32'h0000_00A5);
        bus_write(A_TXDATA, 32'h0000_003C);
        a_start = m_last_start;
        repeat (10) @(negedge clk);
        bus_write(A_DIV, 1000);
        bus_read(A_DIV, rd);     check("div_readback_1000", rd, 1000);
        wait_drain(12000);
        check("div_change_next_frame", last_fall - a_start, 40);
        bus_write(A_DIV, 0);
        bus_read(A_DIV, rd);     check("div_zero_as_one", rd, 1);
        bus_write(A_TXDATA, 32'h0000_00C3);
        busy_span(span, 100);
        check("busy_span_div1", span, 10);
        wait_drain(200);

        // Push into a full FIFO on the same edge as a pop
        bus_write(A_DIV, 2);
        for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'(8'h80 + i));
        target = m_last_start + 20;
        @(negedge clk);
        while (cyc + 1 < target) @(negedge clk);
        drive_write(A_TXDATA, 32'h0000_00EE);
        bus_read(A_STATUS, rd);
        check("full_pop_push_status", rd, 32'h0000_070C);
        check("full_pop_push_model", rd, model_status());
        wait_drain(1000);
        bus_write(A_STATUS, 32'd8);

        // Reset in the middle of the data bits
        bus_write(A_DIV, 4);
        bus_write(A_TXDATA, 32'h0000_005A);
        bus_write(A_TXDATA, 32'h0000_00F0);
        repeat (2) @(negedge clk);
        target = m_last_start + 12;
        while (cyc < target) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(A_STATUS, rd);
        check("mid_reset_tx", tx, 1);
        check("mid_reset_status", rd, 32'h0000_0002);
        bus_read(A_DIV, rd);     check("mid_reset_div", rd, 434);
        tcount = 0;
        prev_tx = tx;
        repeat (100) begin
            @(negedge clk);
            if (tx !== prev_tx) tcount++;
            prev_tx = tx;
        end
        check("mid_reset_no_tx_activity", tcount, 0);

        // Randomised traffic against the model
        bus_write(A_DIV, 3);
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 19);
            if (op < 12) begin
                bus_write(A_TXDATA | 8'($urandom_range(0, 3)), $urandom);
            end else if (op < 14) begin
                bus_write(A_DIV, 32'($urandom_range(0, 5)));
            end else if (op < 16) begin
                bus_write(A_STATUS, 32'($urandom_range(0, 15)));
            end else if (op < 18) begin
                bus_read(A_STATUS, rd);
                check("rand_status", rd, model_status());
            end else begin
                bus_read(A_DIV, rd);
                check("rand_div", rd, m_div);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_drain(20000);
        bus_read(A_STATUS, rd);
        check("final_status", rd, model_status());
        check("final_scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
